// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - shared state encoding, msg field layout and field helpers for the wash sequencer
package wash_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } wash_state_e;

    localparam int MSG_W      = 26;
    localparam int NUM_FIELDS = 8;

    // Stage 0 is the most-significant field; the view controller decodes with the same table.
    localparam int FIELD_MSB [NUM_FIELDS] = '{25, 22, 18, 15, 12, 9, 5, 2};
    localparam int FIELD_LSB [NUM_FIELDS] = '{23, 19, 16, 13, 10, 6, 3, 0};

    function automatic logic [MSG_W-1:0] field_mask(input int idx);
        logic [MSG_W-1:0] m;
        m = '0;
        for (int b = 0; b < MSG_W; b++) begin
            if (b >= FIELD_LSB[idx] && b <= FIELD_MSB[idx]) m[b] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [2:0] first_nonzero(input logic [MSG_W-1:0] m);
        logic [2:0] idx;
        idx = 3'd7;
        for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
            if ((m & field_mask(i)) != '0) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/unit_prescaler.sv
// rtl/unit_prescaler.sv - time-unit prescaler; wrap pulses on the last cycle of each unit while enabled
module unit_prescaler #(
    parameter int UNIT_CYCLES = 50_000_000
) (
    input  logic cp,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic wrap
);

    localparam int            CW   = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

    logic [CW-1:0] r_count;

    // A disabled counter holds its value, so a pause landing on LAST resumes straight into a wrap.
    always_ff @(posedge cp) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign wrap = enable && !clear && (r_count == LAST);

endmodule

// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - stage-time sequencer with pause/resume/abort; WASH_STAGE_SKIP_EN adds a skip input
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int UNIT_CYCLES = 50_000_000,
    parameter int ALARM_UNITS = 3
) (
    input  logic             cp,
    input  logic             reset,
    input  logic [MSG_W-1:0] prog,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
`ifdef WASH_STAGE_SKIP_EN
    input  logic             skip,
`endif
    output logic [MSG_W-1:0] msg,
    output logic [2:0]       stage,
    output logic             running,
    output logic             paused,
    output logic             finish,
    output logic             alarm
);

    localparam int            AW       = (ALARM_UNITS > 0) ? $clog2(ALARM_UNITS + 1) : 1;
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_UNITS - 1);

    wash_state_e      r_state;
    wash_state_e      w_next;
    logic [MSG_W-1:0] r_msg;
    logic             r_finish;
    logic [AW-1:0]    r_alarm_cnt;

    logic             w_skip;
    logic             w_start_ok;
    logic             w_wrap;
    logic             w_ps_enable;
    logic             w_ps_clear;
    logic [2:0]       w_stage;
    logic [MSG_W-1:0] w_msg_dec;
    logic [MSG_W-1:0] w_msg_skip;
    logic             w_finish_evt;

`ifdef WASH_STAGE_SKIP_EN
    assign w_skip = skip && !abort && (r_state == ST_RUN || r_state == ST_PAUSE);
`else
    assign w_skip = 1'b0;
`endif

    assign w_start_ok = start && (prog != '0);
    assign w_stage    = first_nonzero(r_msg);
    // The target field is non-zero, so subtracting its LSB weight never borrows past the field.
    assign w_msg_dec  = r_msg - (MSG_W'(1) << FIELD_LSB[w_stage]);
    assign w_msg_skip = r_msg & ~field_mask(int'(w_stage));

    assign w_ps_enable = (r_state == ST_RUN  && !abort && !w_skip && !pause) ||
                         (r_state == ST_DONE && !abort && !start);
    assign w_ps_clear  = abort || w_skip ||
                         (r_state == ST_IDLE && w_start_ok) ||
                         (r_state == ST_DONE && start);

    unit_prescaler #(.UNIT_CYCLES(UNIT_CYCLES)) u_prescaler (
        .cp     (cp),
        .reset  (reset),
        .clear  (w_ps_clear),
        .enable (w_ps_enable),
        .wrap   (w_wrap)
    );

    always_ff @(posedge cp) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_start_ok) w_next = ST_RUN;
                ST_RUN: begin
                    if (w_skip)                            w_next = (w_msg_skip == '0) ? ST_DONE : ST_RUN;
                    else if (pause)                        w_next = ST_PAUSE;
                    else if (w_wrap && w_msg_dec == '0)    w_next = ST_DONE;
                end
                ST_PAUSE: begin
                    if (w_skip)                            w_next = (w_msg_skip == '0) ? ST_DONE : ST_PAUSE;
                    else if (start)                        w_next = ST_RUN;
                end
                ST_DONE: begin
                    if (start)                             w_next = ST_IDLE;
                    else if (w_wrap && r_alarm_cnt == ALARM_LAST) w_next = ST_IDLE;
                end
                default:                                   w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        running = (r_state == ST_RUN);
        paused  = (r_state == ST_PAUSE);
        alarm   = (r_state == ST_DONE);
        msg     = r_msg;
        stage   = w_stage;
        finish  = r_finish;
    end

    assign w_finish_evt = (r_state != ST_DONE) && (w_next == ST_DONE);

    always_ff @(posedge cp) begin
        if (reset) begin
            r_msg       <= '0;
            r_finish    <= 1'b0;
            r_alarm_cnt <= '0;
        end else begin
            r_finish <= w_finish_evt;
            if (abort)                                r_msg <= '0;
            else if (r_state == ST_IDLE && w_start_ok) r_msg <= prog;
            else if (w_skip)                          r_msg <= w_msg_skip;
            else if (r_state == ST_RUN && w_wrap)     r_msg <= w_msg_dec;

            if (w_finish_evt)                         r_alarm_cnt <= '0;
            else if (r_state == ST_DONE && w_wrap)    r_alarm_cnt <= r_alarm_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_wash_sequencer.sv
// tb/tb_wash_sequencer.sv - table-driven and scoreboard bench for wash_sequencer (UNIT_CYCLES=4, ALARM_UNITS=2)
module tb_wash_sequencer;

    localparam int UNIT  = 4;
    localparam int ALARM = 2;
    localparam int T_LSB [8] = '{23, 19, 16, 13, 10, 6, 3, 0};
    localparam int T_W   [8] = '{3, 4, 3, 3, 3, 4, 3, 3};

    logic        cp;
    logic        reset;
    logic [25:0] prog;
    logic        start;
    logic        pause;
    logic        abort;
`ifdef WASH_STAGE_SKIP_EN
    logic        skip;
`endif
    logic [25:0] msg;
    logic [2:0]  stage;
    logic        running;
    logic        paused;
    logic        finish;
    logic        alarm;

    wash_sequencer #(.UNIT_CYCLES(UNIT), .ALARM_UNITS(ALARM)) dut (
        .cp      (cp),
        .reset   (reset),
        .prog    (prog),
        .start   (start),
        .pause   (pause),
        .abort   (abort),
`ifdef WASH_STAGE_SKIP_EN
        .skip    (skip),
`endif
        .msg     (msg),
        .stage   (stage),
        .running (running),
        .paused  (paused),
        .finish  (finish),
        .alarm   (alarm)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    typedef struct {
        logic [25:0] msg;
        logic [2:0]  stage;
    } sb_t;

    typedef struct {
        logic [25:0] prog;
        int          pause_at;
        int          pause_len;
        int          exp_cycles;
    } vec_t;

    sb_t         exp_q[$];
    vec_t        vecs[6];
    int          n_chk;
    int          n_err;
    bit          mon_en;
    logic [25:0] prev_msg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] fld(input logic [25:0] m, input int i);
        return 4'((m >> T_LSB[i]) & ((26'd1 << T_W[i]) - 26'd1));
    endfunction

    function automatic logic [2:0] model_stage(input logic [25:0] m);
        for (int i = 0; i < 8; i++) if (fld(m, i) != 4'd0) return 3'(i);
        return 3'd7;
    endfunction

    function automatic logic [25:0] model_dec(input logic [25:0] m);
        logic [3:0] f;
        for (int i = 0; i < 8; i++) begin
            f = fld(m, i);
            if (f != 4'd0)
                return (m & ~(((26'd1 << T_W[i]) - 26'd1) << T_LSB[i])) | (26'(f - 4'd1) << T_LSB[i]);
        end
        return m;
    endfunction

    task automatic push(input logic [25:0] m);
        sb_t e;
        e.msg   = m;
        e.stage = model_stage(m);
        exp_q.push_back(e);
    endtask

    task automatic push_run(input logic [25:0] p);
        logic [25:0] m;
        m = p;
        push(m);
        for (int k = 0; k < 200 && m != 26'd0; k++) begin
            m = model_dec(m);
            push(m);
        end
    endtask

    task automatic tick;
        @(posedge cp);
        #1;
    endtask

    // Every change of msg must match the next expected value, with stage decoded alongside it.
    always @(posedge cp) begin
        #1;
        if (mon_en && msg !== prev_msg) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_msg", 32'(msg), 32'(prev_msg));
            end else begin
                sb_t e;
                e = exp_q.pop_front();
                check("sb_msg", 32'(msg), 32'(e.msg));
                check("sb_stage", 32'(stage), 32'(e.stage));
            end
        end
        prev_msg = msg;
    end

    initial begin
        int c;
        int hi;
        bit seen;

        n_chk  = 0;
        n_err  = 0;
        mon_en = 0;
        reset  = 1'b1;
        prog   = '0;
        start  = 1'b0;
        pause  = 1'b0;
        abort  = 1'b0;
`ifdef WASH_STAGE_SKIP_EN
        skip   = 1'b0;
`endif
        vecs[0] = '{26'h0000009, 0, 0, 8};
        vecs[1] = '{26'h1080000, 0, 0, 12};
        vecs[2] = '{26'h1080000, 5, 10, 22};
        vecs[3] = '{26'h0000009, 4, 10, 18};
        vecs[4] = '{26'h3FFFFFF, 0, 0, 288};
        vecs[5] = '{26'h0000005, 0, 0, 20};

        repeat (2) tick();
        reset = 1'b0;
        check("rst_msg", 32'(msg), 0);
        check("rst_stage", 32'(stage), 7);
        check("rst_running", 32'(running), 0);
        check("rst_paused", 32'(paused), 0);
        check("rst_finish", 32'(finish), 0);
        check("rst_alarm", 32'(alarm), 0);
        mon_en = 1;

        for (int v = 0; v < 6; v++) begin
            push_run(vecs[v].prog);
            prog  = vecs[v].prog;
            start = 1'b1;
            tick();
            start = 1'b0;
            prog  = ~vecs[v].prog;
            check("vec_running_after_start", 32'(running), 1);
            c = 0;
            while (!finish && c < 400) begin
                c++;
                pause = (vecs[v].pause_at > 0) && (c == vecs[v].pause_at);
                start = (vecs[v].pause_at > 0) && (c == vecs[v].pause_at + vecs[v].pause_len - 1);
                tick();
                pause = 1'b0;
                start = 1'b0;
                if (vecs[v].pause_at > 0 && c == vecs[v].pause_at)
                    check("vec_paused", 32'(paused), 1);
            end
            check("vec_run_cycles", 32'(c), 32'(vecs[v].exp_cycles));
            check("vec_alarm_at_finish", 32'(alarm), 1);
            check("vec_running_at_finish", 32'(running), 0);
            hi = 1;
            while (alarm && hi < 100) begin
                tick();
                if (alarm) hi++;
            end
            check("vec_alarm_cycles", 32'(hi), 32'(ALARM * UNIT));
            check("vec_idle_running", 32'(running), 0);
            check("vec_idle_stage", 32'(stage), 7);
            check("vec_queue_drained", 32'(exp_q.size()), 0);
        end

        // Pause on a wrap cycle: the decrement is deferred to the cycle after resume.
        push_run(26'h0000008);
        prog = 26'h0000008; start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        pause = 1'b1; tick(); pause = 1'b0;
        check("pw_msg_held", 32'(msg), 32'h8);
        check("pw_paused", 32'(paused), 1);
        repeat (3) tick();
        start = 1'b1; tick(); start = 1'b0;
        check("pw_resume_running", 32'(running), 1);
        check("pw_no_dec_on_resume", 32'(msg), 32'h8);
        tick();
        check("pw_dec_after_resume", 32'(msg), 0);
        check("pw_finish", 32'(finish), 1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("pw_abort_done_alarm", 32'(alarm), 0);

        // Abort mid-run returns to IDLE without a finish pulse.
        push(26'h0000009); push(26'h0);
        prog = 26'h0000009; start = 1'b1; tick(); start = 1'b0;
        repeat (2) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_msg", 32'(msg), 0);
        check("abort_running", 32'(running), 0);
        seen = finish;
        repeat (10) begin tick(); seen |= finish; end
        check("abort_no_finish", 32'(seen), 0);

        prog = 26'h0; start = 1'b1; tick(); start = 1'b0;
        check("zero_prog_idle", 32'(running), 0);

        // start in DONE goes to IDLE and does not begin a new run.
        push_run(26'h0000001);
        prog = 26'h0000001; start = 1'b1; tick(); start = 1'b0;
        c = 0;
        while (!finish && c < 50) begin c++; tick(); end
        check("done_run_cycles", 32'(c), 32'(UNIT));
        start = 1'b1; tick(); start = 1'b0;
        check("done_start_alarm", 32'(alarm), 0);
        tick();
        check("done_start_no_run", 32'(running), 0);

        // Reset mid-run.
        push(26'h1080000); push(26'h0);
        prog = 26'h1080000; start = 1'b1; tick(); start = 1'b0;
        repeat (2) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_rst_msg", 32'(msg), 0);
        check("mid_rst_stage", 32'(stage), 7);
        check("mid_rst_running", 32'(running), 0);
        check("mid_rst_paused", 32'(paused), 0);
        check("mid_rst_finish", 32'(finish), 0);
        check("mid_rst_alarm", 32'(alarm), 0);
        repeat (4) tick();
        check("mid_rst_stays_idle", 32'(running), 0);

`ifdef WASH_STAGE_SKIP_EN
        push(26'h0000008); push(26'h0);
        prog = 26'h0000008; start = 1'b1; tick(); start = 1'b0;
        repeat (2) tick();
        skip = 1'b1; tick(); skip = 1'b0;
        check("skip_msg", 32'(msg), 0);
        check("skip_finish", 32'(finish), 1);
        check("skip_alarm", 32'(alarm), 1);
        abort = 1'b1; tick(); abort = 1'b0;
`endif

        tick();
        check("final_queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
